// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - handshaked byte/half/word data memory with wait states and access checks
module dmem_lsu #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        r_write, r_unsigned;
   logic [1:0]  r_size;
   logic [31:0] r_addr, r_wdata;

   logic        accept, commit;
   logic        c_write, c_unsigned, c_err;
   logic [1:0]  c_size;
   logic [31:0] c_addr, c_wdata, c_word, c_shift, ld_data, st_lanes;
   logic [3:0]  st_be;
   logic [AW-1:0] c_widx;

   logic [31:0] mem [DEPTH] = '{default: '0};

   assign accept = (state == S_IDLE) && req_valid;
   assign commit = rst_n && ((accept && (LATENCY == 0)) || ((state == S_WAIT) && (cnt == 4'd0)));

   // With no wait states the commit edge is the accept edge, so the live request is used.
   assign c_write    = (state == S_IDLE) ? req_write    : r_write;
   assign c_size     = (state == S_IDLE) ? req_size     : r_size;
   assign c_unsigned = (state == S_IDLE) ? req_unsigned : r_unsigned;
   assign c_addr     = (state == S_IDLE) ? req_addr     : r_addr;
   assign c_wdata    = (state == S_IDLE) ? req_wdata    : r_wdata;
   assign c_widx     = c_addr[AW+1:2];
   assign c_word     = mem[c_widx];

   always_comb begin
      c_err = 1'b0;
      case (c_size)
         2'b00:   c_err = 1'b0;
         2'b01:   c_err = c_addr[0];
         2'b10:   c_err = |c_addr[1:0];
         default: c_err = 1'b1;
      endcase
      if ({2'b00, c_addr[31:2]} >= 32'(DEPTH)) c_err = 1'b1;
   end

   always_comb begin
      c_shift = c_word >> {c_addr[1:0], 3'b000};
      case (c_size)
         2'b00:   ld_data = {{24{~c_unsigned & c_shift[7]}}, c_shift[7:0]};
         2'b01:   ld_data = {{16{~c_unsigned & c_shift[15]}}, c_shift[15:0]};
         default: ld_data = c_word;
      endcase
   end

   always_comb begin
      case (c_size)
         2'b00: begin
            st_lanes = {4{c_wdata[7:0]}};
            st_be    = 4'b0001 << c_addr[1:0];
         end
         2'b01: begin
            st_lanes = {2{c_wdata[15:0]}};
            st_be    = c_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_lanes = c_wdata;
            st_be    = 4'b1111;
         end
      endcase
   end

   // The array has no reset: committed stores survive rst_n.
   always_ff @(posedge clk) begin
      if (commit && c_write && !c_err) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) mem[c_widx][8*i +: 8] <= st_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 4'd0;
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            cnt        <= CNT_INIT;
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            rsp_err   <= c_err;
            rsp_rdata <= (c_err || c_write) ? 32'd0 : ld_data;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = (LATENCY == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 4'd0) state_nx = S_RESP;
         S_RESP:  if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu at LATENCY 0 and 3
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [1:0]  req_size [2];
   logic        req_unsigned [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err [2];

   int checks = 0;
   int errors = 0;
   bit [7:0] ref_mem [2][1024];

   always #5 clk = ~clk;

   dmem_lsu #(.DEPTH(256), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_lsu #(.DEPTH(256), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-addressed memory image; DEPTH is 256 words = 1024 bytes.
   task automatic ref_model(input int d, input bit w, input bit [1:0] sz, input bit u,
                            input bit [31:0] a, input bit [31:0] wd,
                            output bit [31:0] rd, output bit er);
      int nb;
      bit [31:0] v;
      er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a / 4 >= 256);
      rd = 32'd0;
      if (er) return;
      nb = 1 << sz;
      if (w) begin
         for (int i = 0; i < nb; i++) ref_mem[d][a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[d][a + i]) << (8 * i));
         if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rd = v;
      end
   endtask

   task automatic drive_req(input int d, input bit w, input bit [1:0] sz, input bit u,
                            input bit [31:0] a, input bit [31:0] wd);
      req_write[d]    = w;
      req_size[d]     = sz;
      req_unsigned[d] = u;
      req_addr[d]     = a;
      req_wdata[d]    = wd;
      req_valid[d]    = 1'b1;
   endtask

   task automatic scramble_req(input int d);
      req_valid[d]    = 1'b0;
      req_write[d]    = 1'($urandom);
      req_size[d]     = 2'($urandom);
      req_unsigned[d] = 1'($urandom);
      req_addr[d]     = $urandom;
      req_wdata[d]    = $urandom;
   endtask

   task automatic wait_rsp(input int d, output int n);
      n = 0;
      @(negedge clk);
      while (rsp_valid[d] !== 1'b1 && n < 40) begin
         check("req_ready_busy", 32'(req_ready[d]), 32'd0);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic txn(input int d, input bit w, input bit [1:0] sz, input bit u,
                      input bit [31:0] a, input bit [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
      bit [31:0] exp_rd;
      bit exp_er;
      int n;
      ref_model(d, w, sz, u, a, wd, exp_rd, exp_er);
      @(negedge clk);
      drive_req(d, w, sz, u, a, wd);
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1;
      scramble_req(d);
      rsp_ready[d] = 1'($urandom);
      wait_rsp(d, n);
      check("latency", n, lat_of(d));
      rd = rsp_rdata[d];
      er = rsp_err[d];
      rsp_ready[d] = 1'b0;
      check("rdata", rd, exp_rd);
      check("err", 32'(er), 32'(exp_er));
      check("ready_in_resp", 32'(req_ready[d]), 32'd0);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid[d]), 32'd1);
         check("hold_rdata", rsp_rdata[d], rd);
         check("hold_err", 32'(rsp_err[d]), 32'(er));
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check("valid_drop", 32'(rsp_valid[d]), 32'd0);
      rsp_ready[d] = 1'b0;
   endtask

   task automatic reset_during(input int d, input bit [31:0] a, input bit [31:0] wd, input bit in_resp);
      bit [31:0] rd;
      bit er;
      int n;
      @(negedge clk);
      drive_req(d, 1'b1, 2'd2, 1'b0, a, wd);
      @(posedge clk);
      #1;
      scramble_req(d);
      if (in_resp) begin
         ref_model(d, 1'b1, 2'd2, 1'b0, a, wd, rd, er);
         wait_rsp(d, n);
         check("rst_resp_reached", 32'(rsp_valid[d]), 32'd1);
      end else begin
         @(negedge clk);
         check("rst_in_wait", 32'(rsp_valid[d]), 32'd0);
      end
      rst_n = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic bp_test(input int d);
      bit [31:0] ea, eb, wdb, rd0;
      bit ee, ebe, er0;
      logic [31:0] grd;
      logic ger;
      int n;
      wdb = $urandom;
      ref_model(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, ea, ee);
      ref_model(d, 1'b1, 2'd2, 1'b0, 32'h14, wdb, eb, ebe);
      @(negedge clk);
      drive_req(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
      @(posedge clk);
      #1;
      drive_req(d, 1'b1, 2'd2, 1'b0, 32'h14, wdb);
      wait_rsp(d, n);
      check("bp_latency", n, lat_of(d));
      rd0 = rsp_rdata[d];
      er0 = rsp_err[d];
      check("bp_rdata", rd0, ea);
      check("bp_err", 32'(er0), 32'(ee));
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid[d]), 32'd1);
         check("bp_rdata_hold", rsp_rdata[d], rd0);
         check("bp_err_hold", 32'(rsp_err[d]), 32'(er0));
         check("bp_no_accept", 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check("bp_idle_valid", 32'(rsp_valid[d]), 32'd0);
      check("bp_idle_ready", 32'(req_ready[d]), 32'd1);
      @(posedge clk);
      #1;
      scramble_req(d);
      wait_rsp(d, n);
      check("b2b_latency", n, lat_of(d));
      check("b2b_rdata", rsp_rdata[d], eb);
      check("b2b_err", 32'(rsp_err[d]), 32'(ebe));
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      txn(d, 1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 0, grd, ger);
      check("b2b_store_seen", grd, wdb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic er;
      bit w, u;
      bit [1:0] sz;
      bit [31:0] a;
      int r, off;

      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         rsp_ready[d] = 1'b0;
         scramble_req(d);
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_req_ready", 32'(req_ready[d]), 32'd1);
         check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
         check("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      end
      rst_n = 1'b1;

      reset_during(1, 32'h10, 32'hDEADBEEF, 1'b0);
      txn(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
      check("discarded_store", rd, 32'd0);
      reset_during(1, 32'h20, 32'hCAFEF00D, 1'b1);
      txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, rd, er);
      check("committed_store", rd, 32'hCAFEF00D);

      txn(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0, rd, er);
      txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
      check("word_load", rd, 32'h12345678);
      txn(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 0, rd, er);
      txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1, rd, er);
      check("byte_merge", rd, 32'hAB345678);
      txn(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, rd, er);
      check("lb_signed", rd, 32'hFFFFFFAB);
      txn(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, rd, er);
      check("lhu", rd, 32'h0000AB34);
      txn(0, 1'b0, 2'd2, 1'b0, 32'h11, 32'd0, 0, rd, er);
      check("misaligned_err", 32'(er), 32'd1);
      check("misaligned_rdata", rd, 32'd0);
      txn(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h55555555, 0, rd, er);
      check("range_err", 32'(er), 32'd1);
      txn(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 0, rd, er);
      check("range_no_alias", rd, 32'd0);
      txn(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0, rd, er);
      check("size11_err", 32'(er), 32'd1);

      txn(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h8001_7F80, 0, rd, er);
      txn(1, 1'b0, 2'd1, 1'b0, 32'h42, 32'd0, 0, rd, er);
      check("lh_signed_l3", rd, 32'hFFFF8001);

      bp_test(0);
      bp_test(1);

      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom);
         u = 1'($urandom);
         r = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 4) != 0 && sz != 2'd3) off = off & ~((1 << sz) - 1);
         a = 32'($urandom_range(0, 15)) * 4 + 32'(off);
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
         txn(i % 2, w, sz, u, a, $urandom, $urandom_range(0, 2), rd, er);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, handshaked data memory for the RV32 core's load/store path. It replaces the single-cycle word-only data memory with a request/response port that supports:
- byte, halfword and word accesses, with sign or zero extension on loads;
- a configurable number of wait states;
- error reporting for misaligned and out-of-range accesses.

It sits between the core's MEM stage (or its stall logic) and the word-organised data array, which is internal to this block.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; the word index is addr[31:2].
- LATENCY, 0, wait states between accept and response (0..15).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  1 = access rejected.

## Operation
The FSM has three states: IDLE, WAIT and RESP.

- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, capture write, size, unsigned, addr and wdata into request registers.
  - Go to WAIT if LATENCY>0; otherwise go to RESP.
- **WAIT**
  - req_ready=0.
  - The down-counter is loaded with LATENCY-1 at accept and decrements each cycle.
  - Go to RESP on the cycle the counter reaches 0.
- **Commit** happens on the edge that enters RESP:
  - the error check is evaluated on the captured request;
  - if there is no error and write=1, the store is performed;
  - if there is no error and write=0, rsp_rdata is loaded;
  - rsp_err is registered.
- **RESP**
  - rsp_valid=1, req_ready=0.
  - On rsp_ready, go to IDLE; rsp_valid falls on the next cycle.
  - Outputs hold stable until the response is taken.

Error condition (any of these makes rsp_err=1, suppresses the write and forces rsp_rdata=0):
- size=11;
- size=01 and addr[0]=1;
- size=10 and addr[1:0]≠0;
- addr[31:2] ≥ DEPTH.

Store lanes:
- byte: writes lane addr[1:0] with wdata[7:0];
- half: writes lane addr[1] (bytes 2·addr[1]+1 : 2·addr[1]) with wdata[15:0];
- word: writes all four bytes.
- Lanes that are not addressed keep their old value.

Load extraction:
- the same lane is selected;
- bits above the access size are filled with the top bit of the accessed value, or with 0 when unsigned;
- for word loads, req_unsigned is ignored.

Memory array:
- zero-initialised at time 0;
- not cleared by rst_n.

## Timing
Reset values while rst_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.

Reset mid-operation:
- a request still in WAIT is discarded and its store is never performed;
- a store that has already committed (the block is in RESP) remains in memory.

Latency and throughput:
- rsp_valid rises LATENCY+1 cycles after the accepting edge.
- With rsp_ready held at 1, one transaction completes every LATENCY+2 cycles.
- There is no overlap: a new request can only be accepted in IDLE.

Other timing rules:
- req_* inputs are sampled only at the accept edge and may change afterwards.
- req_ready is a function of state only, with no combinational path from req_valid.
- rsp_ready while rsp_valid=0 is ignored.
- Back-to-back requests: req_valid held high across RESP→IDLE is accepted on the first IDLE cycle.
- Loads observe all stores whose responses have already been issued.

## Test plan
- **Reset:** assert rst_n=0 mid-WAIT with a pending store of 0xDEADBEEF to word 4 → after reset req_ready=1, rsp_valid=0, and a later load of word 4 returns 0.
- **Word store then load, LATENCY=0:** store 0x12345678 at 0x10, then load word 0x10 → rsp_valid 1 cycle after accept, rdata=0x12345678, err=0.
- **Byte/half lanes:** over word 0x12345678 at 0x10:
  - store byte 0xAB at 0x13, then load the word → 0xAB345678;
  - load signed byte at 0x13 → 0xFFFFFFAB;
  - load unsigned half at 0x12 → 0x0000AB34.
- **Errors:**
  - load word at 0x11 → err=1, rdata=0;
  - store to addr 0x400 with DEPTH=256 → err=1 and memory unchanged;
  - size=11 → err=1.
- **Wait states, LATENCY=3:** rsp_valid rises exactly 4 cycles after accept; req_ready=0 throughout.
- **Backpressure:** hold rsp_ready=0 for 5 cycles → rsp_valid, rdata and err stay stable and no new request is accepted. Then raise rsp_ready with req_valid already high → the next request is accepted on the first IDLE cycle.
